// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges no-backpressure pipeline results with
// long-latency results buffered in a small FIFO, with a starvation-driven stall.
module writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        stall_req,
  output logic [31:0] pending_mask,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          empty_s, full_s, push_s, pop_s, pipe_sel_s, stall_s;
  logic [31:0]   mask_s;

  assign empty_s  = (count_q == CW'(0));
  assign full_s   = (count_q == FULL_CNT);
  assign stall_s  = (starve_q == STARVE_MAX) && !empty_s;
  // x0 results complete the handshake but are dropped here.
  assign push_s   = mc_valid && !full_s && (mc_rd != 5'd0);

  assign mc_ready     = !full_s;
  assign stall_req    = stall_s;
  assign pending_mask = mask_s;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;

  // Slot selection, FIFO pointer/occupancy and starvation next-state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pipe_sel_s = !stall_s && pipe_valid && (pipe_rd != 5'd0);
    pop_s      = stall_s || (!pipe_sel_s && !empty_s);

    if (pop_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rd_mem_q[head_q];
      wr_data_d = data_mem_q[head_q];
      head_d    = head_q + PW'(1);
    end else if (pipe_sel_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pipe_rd;
      wr_data_d = pipe_data;
    end else begin
      wr_en_d   = 1'b0;
    end

    if (push_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (empty_s || pop_s) begin
      starve_d = SW'(0);
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Pending-destination mask over the live FIFO window.
  always_comb begin
    logic [PW-1:0] slot;
    logic          live;
    mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      slot   = head_q + PW'(i);
      live   = CW'(i) < count_q;
      mask_s = mask_s | ({32{live}} & (32'd1 << rd_mem_q[slot]));
    end
    mask_s[0] = 1'b0;
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= PW'(0);
      tail_q    <= PW'(0);
      count_q   <= CW'(0);
      starve_q  <= SW'(0);
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage; contents are only meaningful inside the live window.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      rd_mem_q[tail_q]   <= mc_rd;
      data_mem_q[tail_q] <= mc_data;
    end
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Owns the single register-file write port (wr_en, wr_addr, wr_data) and is the writer side of that interface.
- Merges two result sources: the in-order pipeline writeback, which has no backpressure, and a long-latency unit (mul/div), which uses a valid/ready handshake.
- Long-latency results wait in a small FIFO until the write port is free.
- Exports a pending-destination mask to the hazard unit, and a stall request that prevents FIFO starvation.

Parameters:
- DEPTH, 2, number of FIFO entries for long-latency results; power of two, ≥2.
- STARVE_LIMIT, 4, cycles a FIFO head may wait unwritten before stall_req asserts; ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pipe_valid  in  1  pipeline result present this cycle
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- mc_valid  in  1  long-latency result offered
- mc_ready  out  1  FIFO can accept; equals !full, combinational
- mc_rd  in  5  long-latency destination register
- mc_data  in  32  long-latency result
- stall_req  out  1  tells the pipeline to hold its writeback
- pending_mask  out  32  bit r set while a FIFO entry targets xr
- wr_en  out  1  register-file write enable, registered
- wr_addr  out  5  register-file write address, registered
- wr_data  out  32  register-file write data, registered

Behaviour:
- Reset (clk edge with rst_n=0):
  - FIFO emptied; starve counter = 0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - Therefore mc_ready=1, stall_req=0, pending_mask=0.
- Slot selection, evaluated once per cycle:
  - If stall_req=1: pop the FIFO head and write it. The pipe result is not taken. Upstream holds pipe_valid, pipe_rd and pipe_data stable until stall_req=0.
  - Else if pipe_valid=1 and pipe_rd≠0: write the pipe result. The FIFO head stays.
  - Else if the FIFO is non-empty: pop the head and write it.
  - Else: no write.
- Write port timing:
  - The selected result appears on wr_en/wr_addr/wr_data at the next edge, i.e. 1-cycle latency from selection.
  - wr_en=0 in any cycle with no selection. wr_addr and wr_data hold their previous values when wr_en=0.
- x0 handling:
  - pipe_valid with pipe_rd=0 writes nothing and does not block the FIFO head.
  - A long-latency result with mc_rd=0 completes the handshake but is not pushed. pending_mask does not change.
- FIFO:
  - Push occurs when mc_valid && mc_ready && mc_rd≠0.
  - When full, mc_ready=0 even if a pop happens in the same cycle. No push-on-full-with-pop.
  - Push and pop in the same cycle are allowed when not full. Occupancy is unchanged in that case.
  - An entry pushed at edge t can be popped no earlier than the cycle after edge t. There is no bypass, so minimum mc-to-wr_en latency is 2 cycles.
  - Order is strict FIFO.
  - Read and write pointers wrap modulo DEPTH. A separate count or extra pointer bit distinguishes full from empty.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_LIMIT.
  - It clears on a pop or when the FIFO is empty.
  - stall_req = (counter == STARVE_LIMIT) && !empty, combinational.
  - stall_req drops in the cycle after the forced pop, because the counter clears. If more entries remain queued, counting restarts from 0.
- pending_mask:
  - Combinational OR of one-hot decodes of the rd of every valid FIFO entry. Bit 0 is always 0.
  - A bit clears in the cycle after its entry is popped. From that cycle, the register file's write-through covers the value.
  - Duplicate rd values in the FIFO keep the bit set until the last matching entry is popped.
- Ordering between sources: write-after-write ordering across pipe and mc is not enforced here. The hazard unit uses pending_mask to prevent it.
- Reset mid-operation: all queued entries are discarded and never written. No write occurs in the cycle following reset.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with traffic applied -> wr_en=0, wr_addr=0, wr_data=0, mc_ready=1, stall_req=0, pending_mask=0.
- Pipe write: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF at cycle t, FIFO empty -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at t+1; wr_en=0 at t+2.
- Long-latency path: mc push rd=7, data=0x00001234 at t, no pipe traffic -> pending_mask=0x80 during t+1; wr_en=1, wr_addr=7 at t+2; pending_mask=0 at t+2.
- Contention and starvation:
  - Stimulus: pipe_valid=1 every cycle with rd=1, data incrementing; mc pushes rd=3, then rd=4.
  - Required: after the 2nd push, mc_ready=0 and pending_mask=0x18; stall_req=1 once the head has waited 4 cycles; rd=3 written on the next write slot, with the held pipe result written afterwards; stall_req=0 the following cycle.
- x0 handling: FIFO holds rd=9 while pipe_valid=1, pipe_rd=0 -> the rd=9 entry is written next cycle. Separately, mc_valid=1, mc_rd=0 -> handshake completes, FIFO occupancy and pending_mask unchanged, no write.
- Reset mid-operation: FIFO full (rd=2, rd=3), rst_n=0 for 1 edge -> mc_ready=1, pending_mask=0, wr_en=0, and neither rd=2 nor rd=3 is ever written.
